os_drain_collector: RTL and testbench

OS_DRAIN_COLLECTOR -- requirements
Module: os_drain_collector

---
 rtl/os_drain_collector.sv | 147 ++++++++++++++
 tb/tb_os_drain_collector.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/os_drain_collector.sv
// os_drain_collector
//   Drains an output-stationary PE array one row at a time. After a settle
//   window it captures the last-row MAC outputs of every column, presents
//   them on a valid/ready output register, pulses cscan_en to shift the
//   chain by one row, and repeats until all ROWS rows are delivered. It then
//   pulses reg_clear/done and returns to IDLE. abort ends a drain early and
//   clears the array; reset abandons it silently.
//
// Ports
//   clk, rst_n   clock, synchronous active-low reset
//   start        one-cycle drain request (sampled in IDLE only)
//   abort        terminate drain and clear the array (ignored in IDLE)
//   mac_col_in   last-row MAC outputs, column c at [c*WIDTH_MAC +: WIDTH_MAC]
//   cscan_en     scan-shift enable broadcast to the PEs
//   reg_clear    one-cycle accumulator clear broadcast to the PEs
//   out_data     captured row
//   out_row      index of captured row (0 = nearest the chain output)
//   out_valid    output beat valid
//   out_ready    consumer ready
//   out_last     marks the beat carrying row ROWS-1
//   busy         high whenever not IDLE
//   done         one-cycle pulse on normal drain completion
//
// state   | meaning
// IDLE    | waiting for start
// SETTLE  | pipeline flush countdown before the first capture
// CAPTURE | load the current chain output into the output register
// SHIFT   | one-cycle scan shift to bring the next row to the chain output
// CLEAR   | wait for the last beat to be taken, then clear the array
module os_drain_collector #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int WIDTH_MAC  = 48,
  parameter int SETTLE_CYC = 2,
  localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [COLS*WIDTH_MAC-1:0] mac_col_in,
  output logic                      cscan_en,
  output logic                      reg_clear,
  output logic [COLS*WIDTH_MAC-1:0] out_data,
  output logic [ROW_W-1:0]          out_row,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETTLE  = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_SHIFT   = 3'd3;
  localparam logic [2:0] S_CLEAR   = 3'd4;

  localparam logic [ROW_W-1:0] LAST_ROW    = ROW_W'(ROWS - 1);
  localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYC);

  logic [2:0]       state;
  logic [7:0]       settle_cnt;
  logic [ROW_W-1:0] row_cnt;
  logic             out_free;
  logic             beat_taken;
  logic             load_beat;

  // The output register can take a new row if it is empty or its current
  // beat leaves on this same edge.
  assign out_free   = ~out_valid | out_ready;
  assign beat_taken = out_valid & out_ready;
  // abort wins over a capture that would otherwise happen on this edge.
  assign load_beat  = (state == S_CAPTURE) & out_free & ~abort;

  assign cscan_en = (state == S_SHIFT);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      row_cnt    <= '0;
      reg_clear  <= 1'b0;
      done       <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_row    <= '0;
      out_last   <= 1'b0;
    end else begin
      reg_clear <= 1'b0;
      done      <= 1'b0;

      if (load_beat) begin
        out_data  <= mac_col_in;
        out_row   <= row_cnt;
        out_last  <= (row_cnt == LAST_ROW);
        out_valid <= 1'b1;
      end else if (beat_taken) begin
        out_valid <= 1'b0;
      end

      if (busy && abort) begin
        state     <= S_IDLE;
        out_valid <= 1'b0;
        reg_clear <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              settle_cnt <= SETTLE_LOAD;
              row_cnt    <= '0;
              state      <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            if (settle_cnt == 8'd0) begin
              state <= S_CAPTURE;
            end else begin
              settle_cnt <= settle_cnt - 8'd1;
            end
          end
          S_CAPTURE: begin
            if (out_free) begin
              state <= (row_cnt == LAST_ROW) ? S_CLEAR : S_SHIFT;
            end
          end
          S_SHIFT: begin
            row_cnt <= row_cnt + 1'b1;
            state   <= S_CAPTURE;
          end
          S_CLEAR: begin
            // Clearing before the last beat leaves would be harmless to the
            // data already held, but done must mean "everything delivered".
            if (out_free) begin
              reg_clear <= 1'b1;
              done      <= 1'b1;
              state     <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_os_drain_collector.sv
// Self-checking bench for os_drain_collector: a main instance (ROWS=4,
// SETTLE_CYC=2) checked every cycle against a beat-timeline model, and a
// ROWS=1/SETTLE_CYC=0 instance checked with literal expectations.
module tb_os_drain_collector;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int WM     = 48;
  localparam int SETTLE = 2;
  localparam int DW     = COLS * WM;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] mac_col_in;
  logic          cscan_en, reg_clear, out_valid, out_last, busy, done;
  logic [DW-1:0] out_data;
  logic [1:0]    out_row;

  logic          s1_start = 1'b0;
  logic          s1_abort = 1'b0;
  logic          s1_ready = 1'b0;
  logic [95:0]   s1_mac;
  logic          s1_cscan, s1_clear, s1_valid, s1_last, s1_busy, s1_done;
  logic [95:0]   s1_data;
  logic [0:0]    s1_row;

  always #5 clk = ~clk;

  os_drain_collector #(.ROWS(ROWS), .COLS(COLS), .WIDTH_MAC(WM), .SETTLE_CYC(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mac_col_in(mac_col_in),
    .cscan_en(cscan_en), .reg_clear(reg_clear), .out_data(out_data), .out_row(out_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
  );

  os_drain_collector #(.ROWS(1), .COLS(2), .WIDTH_MAC(48), .SETTLE_CYC(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1_start), .abort(s1_abort), .mac_col_in(s1_mac),
    .cscan_en(s1_cscan), .reg_clear(s1_clear), .out_data(s1_data), .out_row(s1_row),
    .out_valid(s1_valid), .out_ready(s1_ready), .out_last(s1_last), .busy(s1_busy), .done(s1_done)
  );

  assign s1_mac = {48'h0, 48'hFFFF_FFFF_FFFF};

  // ---------------- PE chain plant ----------------
  logic [DW-1:0] pre   [ROWS];
  logic [DW-1:0] chain [ROWS];
  logic          load_req = 1'b0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < ROWS; i++) chain[i] <= pre[i];
    end else if (reg_clear) begin
      for (int i = 0; i < ROWS; i++) chain[i] <= '0;
    end else if (cscan_en) begin
      for (int i = 0; i < ROWS - 1; i++) chain[i] <= chain[i+1];
      chain[ROWS-1] <= '0;
    end
  end
  assign mac_col_in = chain[0];

  // ---------------- beat-timeline model ----------------
  // Captures may happen at SETTLE+2 edges after start, then no sooner than
  // every second edge, and only when the output register is free.
  int            cyc = 0;
  logic          m_act = 1'b0, m_valid = 1'b0, m_last = 1'b0;
  logic          m_cscan = 1'b0, m_clear = 1'b0, m_done = 1'b0;
  logic [DW-1:0] m_data = '0;
  int            m_row = 0, m_k = 0, m_wait = 0;

  always @(posedge clk) begin
    logic accept, free;
    cyc++;
    accept  = m_valid && out_ready;
    free    = !m_valid || out_ready;
    m_cscan = 1'b0;
    m_clear = 1'b0;
    m_done  = 1'b0;
    if (!rst_n) begin
      m_act = 1'b0; m_valid = 1'b0; m_last = 1'b0; m_row = 0; m_data = '0;
    end else if (m_act && abort) begin
      m_act = 1'b0; m_valid = 1'b0; m_clear = 1'b1;
    end else if (!m_act) begin
      if (accept) m_valid = 1'b0;
      if (start) begin m_act = 1'b1; m_k = 0; m_wait = SETTLE + 1; end
    end else if (m_wait > 0) begin
      m_wait--;
      if (accept) m_valid = 1'b0;
    end else if (free && m_k < ROWS) begin
      m_data  = pre[m_k];
      m_row   = m_k;
      m_last  = (m_k == ROWS - 1);
      m_valid = 1'b1;
      m_cscan = (m_k != ROWS - 1);
      m_k++;
      m_wait  = (m_k == ROWS) ? 0 : 1;
    end else if (free) begin
      m_valid = 1'b0; m_clear = 1'b1; m_done = 1'b1; m_act = 1'b0;
    end
  end

  // ---------------- checking ----------------
  int errors = 0, checks = 0;
  int n_cscan = 0, n_clear = 0, n_done = 0, n_beats = 0, n1_cscan = 0, done_cyc = 0;
  logic [DW-1:0] acc_q [$];
  int            acc_row_q [$];
  logic          acc_last_q [$];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon_cycle();
    if (cscan_en) n_cscan++;
    if (reg_clear) n_clear++;
    if (done) begin n_done++; done_cyc = cyc; end
    if (s1_cscan) n1_cscan++;
    if (out_valid && out_ready) begin
      n_beats++;
      acc_q.push_back(out_data);
      acc_row_q.push_back(int'(out_row));
      acc_last_q.push_back(out_last);
    end
    chk1("busy", busy, m_act);
    chk1("out_valid", out_valid, m_valid);
    chk1("cscan_en", cscan_en, m_cscan);
    chk1("reg_clear", reg_clear, m_clear);
    chk1("done", done, m_done);
    if (m_valid) begin
      chkd("out_data", out_data, m_data);
      chkn("out_row", int'(out_row), m_row);
      chk1("out_last", out_last, m_last);
    end
  endtask

  function automatic logic [DW-1:0] mkrow(input int r, input int seed);
    logic [DW-1:0] v;
    v = '0;
    for (int c = 0; c < COLS; c++)
      v[c*WM +: WM] = {8'(seed), 8'(r), 8'(c), 24'hA5C35A ^ 24'(seed * 97 + r * 13 + c)};
    return v;
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic preload(input int seed);
    for (int r = 0; r < ROWS; r++) pre[r] = mkrow(r, seed);
    load_req = 1'b1;
    step();
    load_req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    while (busy && i < 100) begin step(); i++; end
    chk1(name, busy, 1'b0);
    step();
  endtask

  task automatic check_beats(input string name, input int base, input int seed);
    for (int k = 0; k < ROWS; k++) begin
      if (base + k < acc_q.size()) begin
        chkd({name, " data"}, acc_q[base+k], mkrow(k, seed));
        chkn({name, " row"}, acc_row_q[base+k], k);
        chk1({name, " last"}, acc_last_q[base+k], k == ROWS - 1);
      end else begin
        chkn({name, " missing beat"}, acc_q.size(), base + ROWS);
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e0, b0, c0, d0, r0, base, i;

    // reset state
    step(2);
    chk1("rst out_valid", out_valid, 1'b0);
    chk1("rst busy", busy, 1'b0);
    chk1("rst cscan_en", cscan_en, 1'b0);
    chk1("rst reg_clear", reg_clear, 1'b0);
    chk1("rst done", done, 1'b0);
    chk1("rst out_last", out_last, 1'b0);
    chkd("rst out_data", out_data, '0);
    chkn("rst out_row", int'(out_row), 0);
    chk1("rst s1 out_valid", s1_valid, 1'b0);
    chk1("rst s1 busy", s1_busy, 1'b0);
    fork
      forever @(negedge clk) mon_cycle();
    join_none
    rst_n = 1'b1;
    step();

    // normal drain, ready held high
    preload(1);
    out_ready = 1'b1;
    b0 = n_beats; c0 = n_cscan; d0 = n_done; r0 = n_clear; base = acc_q.size();
    start = 1'b1; e0 = cyc + 1; step(); start = 1'b0;
    wait_idle("t1 finished");
    chkn("t1 beats", n_beats - b0, 4);
    chkn("t1 cscan pulses", n_cscan - c0, 3);
    chkn("t1 done pulses", n_done - d0, 1);
    chkn("t1 clear pulses", n_clear - r0, 1);
    chkn("t1 drain cycles", done_cyc - e0, 11);
    check_beats("t1 beat", base, 1);

    // 5-cycle stall from the first valid beat
    preload(2);
    out_ready = 1'b0;
    b0 = n_beats; c0 = n_cscan; base = acc_q.size();
    start = 1'b1; step(); start = 1'b0;
    i = 0;
    while (!out_valid && i < 20) begin step(); i++; end
    chk1("t2 first beat seen", out_valid, 1'b1);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk); #1;
      chkd("t2 hold A", out_data, mkrow(0, 2));
      chk1("t2 hold valid", out_valid, 1'b1);
      step();
    end
    chkn("t2 cscan while stalled", n_cscan - c0, 1);
    out_ready = 1'b1;
    wait_idle("t2 finished");
    chkn("t2 beats", n_beats - b0, 4);
    chkn("t2 cscan pulses", n_cscan - c0, 3);
    check_beats("t2 beat", base, 2);

    // abort in the cycle after the row-1 beat
    preload(3);
    b0 = n_beats; d0 = n_done; r0 = n_clear;
    start = 1'b1; step(); start = 1'b0;
    i = 0;
    while (!(out_valid && out_row == 2'd1) && i < 30) begin step(); i++; end
    chk1("t3 row1 beat seen", out_valid && out_row == 2'd1, 1'b1);
    step();
    abort = 1'b1; step(); abort = 1'b0;
    chk1("t3 valid after abort", out_valid, 1'b0);
    chk1("t3 reg_clear after abort", reg_clear, 1'b1);
    chk1("t3 done after abort", done, 1'b0);
    chk1("t3 busy after abort", busy, 1'b0);
    step(2);
    chkn("t3 clear pulses", n_clear - r0, 1);
    chkn("t3 done pulses", n_done - d0, 0);
    chkn("t3 beats", n_beats - b0, 2);

    // start while busy is ignored
    preload(4);
    b0 = n_beats; d0 = n_done; c0 = n_cscan; base = acc_q.size();
    start = 1'b1; step(); start = 1'b0;
    step(3);
    start = 1'b1; step(); start = 1'b0;
    step(3);
    start = 1'b1; step(); start = 1'b0;
    wait_idle("t4 finished");
    chkn("t4 beats", n_beats - b0, 4);
    chkn("t4 done pulses", n_done - d0, 1);
    chkn("t4 cscan pulses", n_cscan - c0, 3);
    check_beats("t4 beat", base, 4);

    // reset mid-drain
    preload(5);
    start = 1'b1; step(); start = 1'b0;
    step(6);
    r0 = n_clear;
    rst_n = 1'b0; step();
    chk1("t4r out_valid", out_valid, 1'b0);
    chk1("t4r busy", busy, 1'b0);
    chk1("t4r cscan_en", cscan_en, 1'b0);
    chk1("t4r reg_clear", reg_clear, 1'b0);
    chk1("t4r done", done, 1'b0);
    chk1("t4r out_last", out_last, 1'b0);
    chkd("t4r out_data", out_data, '0);
    chkn("t4r out_row", int'(out_row), 0);
    rst_n = 1'b1;
    step(3);
    chkn("t4r clear pulses", n_clear - r0, 0);
    chk1("t4r stays idle", busy, 1'b0);

    // ROWS=1, SETTLE_CYC=0 instance
    s1_ready = 1'b1;
    s1_start = 1'b1; e0 = cyc + 1; step(); s1_start = 1'b0;
    i = 0;
    while (!s1_valid && i < 20) begin step(); i++; end
    chk1("t5 beat seen", s1_valid, 1'b1);
    chkn("t5 beat latency", cyc - e0, 2);
    chkd("t5 data", DW'(s1_data), DW'({48'h0, 48'hFFFF_FFFF_FFFF}));
    chk1("t5 last", s1_last, 1'b1);
    chkn("t5 row", int'(s1_row), 0);
    step();
    chk1("t5 done", s1_done, 1'b1);
    chk1("t5 reg_clear", s1_clear, 1'b1);
    chk1("t5 valid dropped", s1_valid, 1'b0);
    chk1("t5 busy", s1_busy, 1'b0);
    step(2);
    chkn("t5 cscan pulses", n1_cscan, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
